systolic_mm_engine: RTL and testbench

Self-sequencing output-stationary systolic matrix-multiply engine computing C[X_ROW×Y_COL] = A[X_ROW×K] · B[K×Y_COL] for a run-time inner dimension K ≤ K_MAX. The engine skews its own input wavefronts internally, so the feeder streams one unskewed column of A and one unskewed row of B per beat. A valid/ready input handshake and a start/done control pair wrap the PE grid. The engine is a drop-in compute tile for the matrix-multiply datapath; host/DMA logic drives the input stream and collects the packed result.

---
 rtl/systolic_mm_if.sv | 32 +++
 rtl/systolic_mm_engine.sv | 181 ++++++++++++++++++
 tb/tb_systolic_mm_engine.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_mm_if.sv
// Host-side bundle for systolic_mm_engine: beat handshake, start/done control and packed result.
interface systolic_mm_if #(
    parameter int BITWIDTH                 = 8,
    parameter int IS_BITWIDTH_DOUBLE_SCALE = 0,
    parameter int X_ROW                    = 3,
    parameter int Y_COL                    = 3,
    parameter int K_MAX                    = 16
);
    localparam int RW = BITWIDTH * (IS_BITWIDTH_DOUBLE_SCALE + 1);
    localparam int KW = $clog2(K_MAX + 1);

    logic                      start;
    logic [KW-1:0]             k_len;
    logic                      in_valid;
    logic                      in_ready;
    logic [X_ROW*BITWIDTH-1:0] a_col;
    logic [Y_COL*BITWIDTH-1:0] b_row;
    logic                      busy;
    logic                      done;
    logic                      out_valid;
    logic [X_ROW*Y_COL*RW-1:0] result;

    modport master (
        output start, k_len, in_valid, a_col, b_row,
        input  in_ready, busy, done, out_valid, result
    );

    modport slave (
        input  start, k_len, in_valid, a_col, b_row,
        output in_ready, busy, done, out_valid, result
    );
endinterface

// File: rtl/systolic_mm_engine.sv
// Output-stationary systolic matrix-multiply tile: C = A*B with internal input skew,
// valid/ready beat intake and a start/done control FSM.
module systolic_mm_engine #(
    parameter int BITWIDTH                 = 8,
    parameter int IS_BITWIDTH_DOUBLE_SCALE = 0,
    parameter int X_ROW                    = 3,
    parameter int Y_COL                    = 3,
    parameter int K_MAX                    = 16
) (
    input  logic         clk,
    input  logic         rst,
    systolic_mm_if.slave bus
);
    localparam int RW        = BITWIDTH * (IS_BITWIDTH_DOUBLE_SCALE + 1);
    localparam int KW        = $clog2(K_MAX + 1);
    localparam int DRAIN_LEN = X_ROW + Y_COL;
    localparam int DW        = $clog2(DRAIN_LEN + 1);
    localparam logic [KW-1:0] K_MAX_V = KW'(K_MAX);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t        state;
    logic [KW-1:0] k_reg;
    logic [KW-1:0] beat_cnt;
    logic [DW-1:0] drain_cnt;
    logic          in_ready_q;
    logic          busy_q;
    logic          done_q;
    logic          out_valid_q;

    logic          start_take;
    logic          beat_take;
    logic [KW-1:0] k_eff;

    assign start_take = bus.start && (state == S_IDLE || state == S_DONE);
    assign beat_take  = bus.in_valid && in_ready_q;
    assign k_eff      = (bus.k_len > K_MAX_V) ? K_MAX_V : bus.k_len;

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            k_reg       <= '0;
            beat_cnt    <= '0;
            drain_cnt   <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_take) begin
                        k_reg    <= k_eff;
                        beat_cnt <= '0;
                        if (k_eff == '0) begin
                            state       <= S_DONE;
                            done_q      <= 1'b1;
                            out_valid_q <= 1'b1;
                            busy_q      <= 1'b0;
                            in_ready_q  <= 1'b0;
                        end else begin
                            state       <= S_LOAD;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b1;
                            in_ready_q  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (beat_take) begin
                        beat_cnt <= beat_cnt + KW'(1);
                        if (beat_cnt + KW'(1) == k_reg) begin
                            in_ready_q <= 1'b0;
                            drain_cnt  <= '0;
                            state      <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Last product lands one edge before this transition.
                    if (drain_cnt == DW'(DRAIN_LEN - 1)) begin
                        state       <= S_DONE;
                        done_q      <= 1'b1;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [BITWIDTH-1:0] a_skew [X_ROW];
    logic [BITWIDTH-1:0] b_skew [Y_COL];

    // Row i of A is delayed i cycles and column j of B j cycles; idle cycles inject zeros.
    for (genvar i = 0; i < X_ROW; i++) begin : g_a_skew
        logic [BITWIDTH-1:0] a_in;
        assign a_in = beat_take ? bus.a_col[(X_ROW-1-i)*BITWIDTH +: BITWIDTH] : '0;
        if (i == 0) begin : g_direct
            assign a_skew[i] = a_in;
        end else begin : g_line
            logic [BITWIDTH-1:0] line [0:i-1];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < i; d++) line[d] <= '0;
                end else begin
                    line[0] <= a_in;
                    for (int d = 1; d < i; d++) line[d] <= line[d-1];
                end
            end
            assign a_skew[i] = line[i-1];
        end
    end

    for (genvar j = 0; j < Y_COL; j++) begin : g_b_skew
        logic [BITWIDTH-1:0] b_in;
        assign b_in = beat_take ? bus.b_row[(Y_COL-1-j)*BITWIDTH +: BITWIDTH] : '0;
        if (j == 0) begin : g_direct
            assign b_skew[j] = b_in;
        end else begin : g_line
            logic [BITWIDTH-1:0] line [0:j-1];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < j; d++) line[d] <= '0;
                end else begin
                    line[0] <= b_in;
                    for (int d = 1; d < j; d++) line[d] <= line[d-1];
                end
            end
            assign b_skew[j] = line[j-1];
        end
    end

    logic [BITWIDTH-1:0] a_pe [X_ROW][Y_COL];
    logic [BITWIDTH-1:0] b_pe [X_ROW][Y_COL];
    logic [RW-1:0]       acc  [X_ROW][Y_COL];

    // NOTE: the PE arrays are reset word by word; a stale operand or sum would leak into the next product.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < X_ROW; i++) begin
                for (int j = 0; j < Y_COL; j++) begin
                    a_pe[i][j] <= '0;
                    b_pe[i][j] <= '0;
                    acc[i][j]  <= '0;
                end
            end
        end else begin
            for (int i = 0; i < X_ROW; i++) a_pe[i][0] <= a_skew[i];
            for (int i = 0; i < X_ROW; i++)
                for (int j = 1; j < Y_COL; j++) a_pe[i][j] <= a_pe[i][j-1];
            for (int j = 0; j < Y_COL; j++) b_pe[0][j] <= b_skew[j];
            for (int i = 1; i < X_ROW; i++)
                for (int j = 0; j < Y_COL; j++) b_pe[i][j] <= b_pe[i-1][j];
            for (int i = 0; i < X_ROW; i++) begin
                for (int j = 0; j < Y_COL; j++) begin
                    if (start_take) acc[i][j] <= '0;
                    else            acc[i][j] <= acc[i][j] + RW'(a_pe[i][j]) * RW'(b_pe[i][j]);
                end
            end
        end
    end

    // NOTE: combinational blocks assign a default first so no path can infer a latch.
    always_comb begin
        bus.result = '0;
        for (int i = 0; i < X_ROW; i++)
            for (int j = 0; j < Y_COL; j++)
                bus.result[(X_ROW*Y_COL-1-(i*Y_COL+j))*RW +: RW] = acc[i][j];
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_systolic_mm_engine.sv
// Self-checking bench: a 3x3/RW=16 tile and a 2x4/RW=8 tile driven in lockstep against a matrix model.
module tb_systolic_mm_engine;
    localparam int K_MAX = 16;
    localparam int KW    = 5;
    localparam int LAT   = 6;   // X_ROW+Y_COL for both tiles

    typedef enum int {OP_SPEC, OP_FF, OP_RAND, OP_IDENT} op_kind_e;

    typedef struct {
        int           k;
        int           stall_at;
        int           stall_len;
        op_kind_e     op;
        bit           mid_start;
        int           exp_lat;
        bit           has_lit;
        logic [143:0] lit3;
        logic [63:0]  lit24;
    } vec_t;

    logic clk;
    logic rst;
    logic start;
    logic [KW-1:0] k_len;
    logic in_valid;
    logic [23:0] a3, b3;
    logic [15:0] a2;
    logic [31:0] b4;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] ma3 [3][K_MAX];
    logic [7:0] mb3 [K_MAX][3];
    logic [7:0] ma2 [2][K_MAX];
    logic [7:0] mb4 [K_MAX][4];

    vec_t tbl [9];

    systolic_mm_if #(.BITWIDTH(8), .IS_BITWIDTH_DOUBLE_SCALE(1), .X_ROW(3), .Y_COL(3), .K_MAX(K_MAX)) bus3 ();
    systolic_mm_if #(.BITWIDTH(8), .IS_BITWIDTH_DOUBLE_SCALE(0), .X_ROW(2), .Y_COL(4), .K_MAX(K_MAX)) bus24 ();

    systolic_mm_engine #(.BITWIDTH(8), .IS_BITWIDTH_DOUBLE_SCALE(1), .X_ROW(3), .Y_COL(3), .K_MAX(K_MAX))
        u_dut3 (.clk(clk), .rst(rst), .bus(bus3));
    systolic_mm_engine #(.BITWIDTH(8), .IS_BITWIDTH_DOUBLE_SCALE(0), .X_ROW(2), .Y_COL(4), .K_MAX(K_MAX))
        u_dut24 (.clk(clk), .rst(rst), .bus(bus24));

    assign bus3.start     = start;
    assign bus3.k_len     = k_len;
    assign bus3.in_valid  = in_valid;
    assign bus3.a_col     = a3;
    assign bus3.b_row     = b3;
    assign bus24.start    = start;
    assign bus24.k_len    = k_len;
    assign bus24.in_valid = in_valid;
    assign bus24.a_col    = a2;
    assign bus24.b_row    = b4;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int k, input int sa, input int sl, input op_kind_e op, input bit ms,
                                input int lat, input bit hl, input logic [143:0] l3, input logic [63:0] l24);
        vec_t v;
        v.k = k; v.stall_at = sa; v.stall_len = sl; v.op = op; v.mid_start = ms;
        v.exp_lat = lat; v.has_lit = hl; v.lit3 = l3; v.lit24 = l24;
        return v;
    endfunction

    // Reference: plain matrix product, each element truncated to the result width.
    function automatic logic [143:0] model3(input int k);
        logic [143:0] r;
        int unsigned  s;
        r = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int kk = 0; kk < k; kk++) s += 32'(ma3[i][kk]) * 32'(mb3[kk][j]);
                r[(8 - (3*i + j))*16 +: 16] = s[15:0];
            end
        return r;
    endfunction

    function automatic logic [63:0] model24(input int k);
        logic [63:0] r;
        int unsigned s;
        r = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int kk = 0; kk < k; kk++) s += 32'(ma2[i][kk]) * 32'(mb4[kk][j]);
                r[(7 - (4*i + j))*8 +: 8] = s[7:0];
            end
        return r;
    endfunction

    task automatic fill_ops(input op_kind_e op);
        logic [7:0] b4s [3][4];
        b4s = '{'{8'd1, 8'd2, 8'd3, 8'd4}, '{8'd5, 8'd5, 8'd6, 8'd6}, '{8'd7, 8'd8, 8'd9, 8'd0}};
        for (int kk = 0; kk < K_MAX; kk++) begin
            for (int i = 0; i < 3; i++) ma3[i][kk] = 8'($urandom);
            for (int j = 0; j < 3; j++) mb3[kk][j] = 8'($urandom);
            for (int i = 0; i < 2; i++) ma2[i][kk] = 8'($urandom);
            for (int j = 0; j < 4; j++) mb4[kk][j] = 8'($urandom);
            if (op == OP_FF) begin
                for (int i = 0; i < 3; i++) ma3[i][kk] = 8'hFF;
                for (int j = 0; j < 3; j++) mb3[kk][j] = 8'hFF;
                for (int i = 0; i < 2; i++) ma2[i][kk] = 8'hFF;
                for (int j = 0; j < 4; j++) mb4[kk][j] = 8'hFF;
            end
            if ((op == OP_SPEC || op == OP_IDENT) && kk < 3) begin
                for (int i = 0; i < 3; i++) ma3[i][kk] = (op == OP_SPEC) ? 8'(3*i + kk + 1) : 8'(i == kk);
                for (int j = 0; j < 3; j++) mb3[kk][j] = 8'(3*kk + 3 - j);
                for (int i = 0; i < 2; i++) ma2[i][kk] = (op == OP_SPEC) ? 8'(3*i + kk + 1) : 8'(i == kk);
                for (int j = 0; j < 4; j++) mb4[kk][j] = b4s[kk][j];
            end
        end
    endtask

    task automatic drive_beat(input int b);
        for (int i = 0; i < 3; i++) a3[(2-i)*8 +: 8] = ma3[i][b];
        for (int j = 0; j < 3; j++) b3[(2-j)*8 +: 8] = mb3[b][j];
        for (int i = 0; i < 2; i++) a2[(1-i)*8 +: 8] = ma2[i][b];
        for (int j = 0; j < 4; j++) b4[(3-j)*8 +: 8] = mb4[b][j];
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  bus3.in_ready,  1'b0);
        check({tag, "_busy"},      bus3.busy,      1'b0);
        check({tag, "_done"},      bus3.done,      1'b0);
        check({tag, "_out_valid"}, bus3.out_valid, 1'b0);
        check({tag, "_result3"},   bus3.result,    '0);
        check({tag, "_out_valid24"}, bus24.out_valid, 1'b0);
        check({tag, "_result24"},  bus24.result,   '0);
    endtask

    task automatic run_job(input int idx, input vec_t v, input bit abort);
        int keff, t_start, t_last, n;
        logic [143:0] e3;
        logic [63:0]  e24;
        string tag;
        tag   = $sformatf("v%0d", idx);
        keff  = (v.k > K_MAX) ? K_MAX : v.k;
        e3    = model3(keff);
        e24   = model24(keff);
        start = 1'b1; k_len = KW'(v.k); in_valid = 1'b0;
        @(posedge clk); #1;
        start   = 1'b0;
        t_start = cyc;
        t_last  = cyc;
        if (keff > 0) begin
            check({tag, "_rdy_rise"},  bus3.in_ready,  1'b1);
            check({tag, "_busy"},      bus3.busy,      1'b1);
            check({tag, "_ov_drop"},   bus3.out_valid, 1'b0);
            check({tag, "_clear3"},    bus3.result,    '0);
            check({tag, "_clear24"},   bus24.result,   '0);
            for (int b = 0; b < keff; b++) begin
                if (b == v.stall_at && v.stall_len > 0) begin
                    in_valid = 1'b0;
                    repeat (v.stall_len) begin @(posedge clk); #1; end
                end
                drive_beat(b);
                in_valid = 1'b1;
                if (v.mid_start && b == 1) begin start = 1'b1; k_len = KW'(1); end
                check($sformatf("%s_rdy_b%0d", tag, b), bus3.in_ready, 1'b1);
                @(posedge clk); #1;
                start  = 1'b0;
                t_last = cyc;
            end
            // Keep offering garbage beats; none may be taken after the K-th.
            a3 = 24'($urandom); b3 = 24'($urandom); a2 = 16'($urandom); b4 = $urandom;
            check({tag, "_rdy_drop"}, bus3.in_ready, 1'b0);
            n = 0;
            while (bus3.done !== 1'b1 && n < 200) begin
                if (v.mid_start && n == 1) begin start = 1'b1; k_len = KW'(2); end
                if (abort && n == 2) rst = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                n++;
                if (rst) begin
                    rst = 1'b0;
                    check_all_zero({tag, "_abort"});
                    @(posedge clk); #1;
                    check({tag, "_idle_rdy"},  bus3.in_ready, 1'b0);
                    check({tag, "_idle_busy"}, bus3.busy,     1'b0);
                    in_valid = 1'b0;
                    return;
                end
            end
            check({tag, "_last_to_done"}, 32'(cyc - t_last), 32'(LAT));
        end
        check({tag, "_done"},      bus3.done,       1'b1);
        check({tag, "_done24"},    bus24.done,      1'b1);
        check({tag, "_out_valid"}, bus3.out_valid,  1'b1);
        check({tag, "_busy_off"},  bus3.busy,       1'b0);
        check({tag, "_latency"},   32'(cyc - t_start), 32'(v.exp_lat));
        check({tag, "_result3"},   bus3.result,     e3);
        check({tag, "_result24"},  bus24.result,    e24);
        if (v.has_lit) begin
            check({tag, "_lit3"},  bus3.result,  v.lit3);
            check({tag, "_lit24"}, bus24.result, v.lit24);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, bus3.done,      1'b0);
        check({tag, "_ov_hold"},    bus3.out_valid, 1'b1);
        check({tag, "_res_hold"},   bus3.result,    e3);
    endtask

    initial begin
        logic [143:0] spec3, id3;
        logic [63:0]  spec24, id24;
        spec3  = 144'h002A_0024_001E_0060_0051_0042_0096_007E_0066;
        spec24 = 64'h2024_2A10_4751_602E;
        id3    = 144'h0003_0002_0001_0006_0005_0004_0009_0008_0007;
        id24   = 64'h0102_0304_0505_0606;

        tbl[0] = mk(3,  -1, 0, OP_SPEC,  1'b0, 9,  1'b1, spec3, spec24);
        tbl[1] = mk(3,   1, 2, OP_SPEC,  1'b0, 11, 1'b1, spec3, spec24);
        tbl[2] = mk(3,  -1, 0, OP_FF,    1'b0, 9,  1'b1, {9{16'hFA03}}, {8{8'h03}});
        tbl[3] = mk(5,  -1, 0, OP_RAND,  1'b1, 11, 1'b0, '0, '0);
        tbl[4] = mk(16,  7, 3, OP_RAND,  1'b0, 25, 1'b0, '0, '0);
        tbl[5] = mk(21, -1, 0, OP_RAND,  1'b0, 22, 1'b0, '0, '0);
        tbl[6] = mk(0,  -1, 0, OP_RAND,  1'b0, 0,  1'b1, '0, '0);
        tbl[7] = mk(3,  -1, 0, OP_IDENT, 1'b0, 9,  1'b1, id3, id24);
        tbl[8] = mk(1,  -1, 0, OP_RAND,  1'b0, 7,  1'b0, '0, '0);

        rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
        a3 = '0; b3 = '0; a2 = '0; b4 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_all_zero("post_reset");

        for (int idx = 0; idx < 9; idx++) begin
            fill_ops(tbl[idx].op);
            run_job(idx, tbl[idx], 1'b0);
        end

        fill_ops(OP_RAND);
        run_job(100, tbl[0], 1'b1);
        fill_ops(OP_SPEC);
        run_job(101, tbl[0], 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
